// File: rtl/fp_add_arbiter_if.sv
// Bundle of request, adder and result signals between two requesters, the
// scheduler and the shared adder pipeline.
interface fp_add_arbiter_if #(
  parameter int OP_W = 35
);
  logic            req0_valid;
  logic            req1_valid;
  logic            req0_ready;
  logic            req1_ready;
  logic [OP_W-1:0] req0_a;
  logic [OP_W-1:0] req0_b;
  logic [OP_W-1:0] req1_a;
  logic [OP_W-1:0] req1_b;
  logic            drain_i;
  logic            add_valid_o;
  logic [OP_W-1:0] add_a_o;
  logic [OP_W-1:0] add_b_o;
  logic [OP_W-1:0] add_result_i;
  logic            res0_valid;
  logic            res1_valid;
  logic [OP_W-1:0] res_data;
  logic            busy;

  // Scheduler side
  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    input  drain_i, add_result_i,
    output req0_ready, req1_ready, add_valid_o, add_a_o, add_b_o,
    output res0_valid, res1_valid, res_data, busy
  );

  // Requester / adder environment side
  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    output drain_i, add_result_i,
    input  req0_ready, req1_ready, add_valid_o, add_a_o, add_b_o,
    input  res0_valid, res1_valid, res_data, busy
  );
endinterface

// File: rtl/fp_add_arbiter.sv
// Round-robin scheduler sharing one fixed-latency FP adder between two
// requesters; each issued operation carries its requester ID down a tag
// pipeline so the result can be steered back to its owner.
module fp_add_arbiter #(
  parameter int SIZE_MANTISSA        = 24,
  parameter int SIZE_EXPONENT        = 8,
  parameter int SIZE_EXCEPTION_FIELD = 2,
  parameter int LATENCY              = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  fp_add_arbiter_if.slave   bus
);
  localparam int OP_W = SIZE_EXCEPTION_FIELD + 1 + SIZE_EXPONENT + SIZE_MANTISSA;

  logic            prio_q, prio_d;
  logic            gnt0, gnt1, hs;
  logic            add_valid_q, add_valid_d;
  logic [OP_W-1:0] add_a_q, add_a_d;
  logic [OP_W-1:0] add_b_q, add_b_d;
  logic            issue_id_q, issue_id_d;
  logic [LATENCY-1:0] tag_vld_q;
  logic [LATENCY-1:0] tag_id_q;
  logic            res0_q, res1_q;
  logic [OP_W-1:0] res_data_q;
  logic            tap_vld, tap_id;

  // Grant: drain or reset blocks everything; contention resolved by prio
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n && !bus.drain_i) begin
      if (bus.req0_valid && !bus.req1_valid) begin
        gnt0 = 1'b1;
      end else if (bus.req1_valid && !bus.req0_valid) begin
        gnt1 = 1'b1;
      end else if (bus.req0_valid && bus.req1_valid) begin
        gnt0 = ~prio_q;
        gnt1 = prio_q;
      end
    end
  end

  // Ready is only raised towards a valid requester, so a grant is a handshake
  assign hs = gnt0 | gnt1;

  // Next-state for the pointer and the issue registers
  always_comb begin
    prio_d      = hs ? ~gnt1 : prio_q;
    add_valid_d = hs;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    issue_id_d  = issue_id_q;
    if (hs) begin
      add_a_d    = gnt1 ? bus.req1_a : bus.req0_a;
      add_b_d    = gnt1 ? bus.req1_b : bus.req0_b;
      issue_id_d = gnt1;
    end
  end

  // Priority pointer and registered issue to the adder
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q      <= 1'b0;
      add_valid_q <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      issue_id_q  <= 1'b0;
    end else begin
      prio_q      <= prio_d;
      add_valid_q <= add_valid_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      issue_id_q  <= issue_id_d;
    end
  end

  // Tag pipeline fed from the issue stage; its last stage lines up with add_result_i
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_vld_q <= '0;
      tag_id_q  <= '0;
    end else begin
      tag_vld_q[0] <= add_valid_q;
      tag_id_q[0]  <= issue_id_q;
      for (int i = 1; i < LATENCY; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
    end
  end

  assign tap_vld = tag_vld_q[LATENCY-1];
  assign tap_id  = tag_id_q[LATENCY-1];

  // Capture a returning result and strobe the requester that issued it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res0_q     <= 1'b0;
      res1_q     <= 1'b0;
      res_data_q <= '0;
    end else begin
      res0_q <= tap_vld & ~tap_id;
      res1_q <= tap_vld & tap_id;
      if (tap_vld) begin
        res_data_q <= bus.add_result_i;
      end
    end
  end

  assign bus.req0_ready  = gnt0;
  assign bus.req1_ready  = gnt1;
  assign bus.add_valid_o = add_valid_q;
  assign bus.add_a_o     = add_a_q;
  assign bus.add_b_o     = add_b_q;
  assign bus.res0_valid  = res0_q;
  assign bus.res1_valid  = res1_q;
  assign bus.res_data    = res_data_q;
  assign bus.busy        = add_valid_q | (|tag_vld_q) | res0_q | res1_q;
endmodule

// File: tb/tb_fp_add_arbiter.sv
module tb_fp_add_arbiter;
  localparam int LAT  = 4;
  localparam int OP_W = 35;
  localparam logic [OP_W-1:0] JUNK = 35'h5A5A5A5A5;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   nres = 0;
  int   res1_cnt = 0;
  int   base;

  fp_add_arbiter_if #(.OP_W(OP_W)) bus ();

  fp_add_arbiter #(
    .SIZE_MANTISSA(24), .SIZE_EXPONENT(8), .SIZE_EXCEPTION_FIELD(2), .LATENCY(LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Model adder: plain LAT-deep pipeline returning a+b, junk when idle
  logic [OP_W-1:0] pipe [LAT];
  initial for (int i = 0; i < LAT; i++) pipe[i] = JUNK;
  always @(posedge clk) begin
    pipe[0] <= bus.add_valid_o ? (bus.add_a_o + bus.add_b_o) : JUNK;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.add_result_i = pipe[LAT-1];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scoreboard: every handshake must come back to its owner 6 cycles later
  typedef struct {
    int              c;
    logic            id;
    logic [OP_W-1:0] d;
  } exp_t;
  exp_t exp_q [$];

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (bus.res0_valid || bus.res1_valid) begin
        nres++;
        if (bus.res1_valid) res1_cnt++;
        check("res_onehot", {bus.res1_valid, bus.res0_valid} == 2'b11, 1'b0);
        if (exp_q.size() == 0) begin
          check("res_spurious", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("res_id", bus.res1_valid, e.id);
          check("res_data", bus.res_data, e.d);
          check("res_lat", cyc - e.c, 2 + LAT);
        end
      end
      if (bus.req0_valid && bus.req0_ready) exp_q.push_back('{cyc, 1'b0, bus.req0_a + bus.req0_b});
      if (bus.req1_valid && bus.req1_ready) exp_q.push_back('{cyc, 1'b1, bus.req1_a + bus.req1_b});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; bus.drain_i = 1'b0;
    bus.req0_a = 35'h7; bus.req0_b = 35'h8; bus.req1_a = 35'h9; bus.req1_b = 35'hA;

    // Reset state, ready lines gated while in reset
    repeat (3) tick();
    @(negedge clk);
    check("rst_ready", {bus.req1_ready, bus.req0_ready}, 2'b00);
    check("rst_add_valid", bus.add_valid_o, 1'b0);
    check("rst_add_a", bus.add_a_o, 0);
    check("rst_add_b", bus.add_b_o, 0);
    check("rst_res", {bus.res1_valid, bus.res0_valid}, 2'b00);
    check("rst_res_data", bus.res_data, 0);
    check("rst_busy", bus.busy, 1'b0);
    tick();
    rst_n = 1'b1; bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;

    // Single op from requester 0
    tick();
    bus.req0_valid = 1'b1; bus.req0_a = 35'h100; bus.req0_b = 35'h23;
    @(negedge clk);
    check("t1_ready0", bus.req0_ready, 1'b1);
    check("t1_ready1", bus.req1_ready, 1'b0);
    tick();
    bus.req0_valid = 1'b0;
    @(negedge clk);
    check("t1_add_valid", bus.add_valid_o, 1'b1);
    check("t1_add_a", bus.add_a_o, 35'h100);
    check("t1_add_b", bus.add_b_o, 35'h23);
    for (int k = 2; k <= 5; k++) begin
      tick();
      @(negedge clk);
      check("t1_res_early", {bus.res1_valid, bus.res0_valid}, 2'b00);
    end
    tick();
    @(negedge clk);
    check("t1_res0", bus.res0_valid, 1'b1);
    check("t1_res1", bus.res1_valid, 1'b0);
    check("t1_data", bus.res_data, 35'h123);
    tick();
    @(negedge clk);
    check("t1_res0_off", bus.res0_valid, 1'b0);
    check("t1_busy_off", bus.busy, 1'b0);
    check("t1_data_hold", bus.res_data, 35'h123);

    // Solo streaming from requester 1
    base = res1_cnt;
    for (int k = 0; k < 4; k++) begin
      tick();
      bus.req1_valid = 1'b1; bus.req1_a = 35'h200 + k; bus.req1_b = 35'h10 * k;
      @(negedge clk);
      check("solo_ready1", bus.req1_ready, 1'b1);
    end
    tick();
    bus.req1_valid = 1'b0;
    repeat (8) tick();
    @(negedge clk);
    check("solo_count", res1_cnt - base, 4);

    // Contention: grants alternate starting from requester 0
    for (int k = 0; k < 6; k++) begin
      tick();
      bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
      bus.req0_a = 35'h300 + k; bus.req0_b = 35'h1;
      bus.req1_a = 35'h400 + k; bus.req1_b = 35'h2;
      @(negedge clk);
      check("cont_grant", {bus.req1_ready, bus.req0_ready}, (k % 2) ? 2'b10 : 2'b01);
    end
    tick();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    repeat (8) tick();

    // Drain with three ops in flight while both requesters stay valid
    for (int k = 0; k < 3; k++) begin
      tick();
      bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
      bus.req0_a = 35'h600 + k; bus.req0_b = 35'h3;
      bus.req1_a = 35'h700 + k; bus.req1_b = 35'h4;
      @(negedge clk);
      check("drn_grant", {bus.req1_ready, bus.req0_ready}, (k % 2) ? 2'b10 : 2'b01);
    end
    base = nres;
    for (int j = 0; j < 8; j++) begin
      tick();
      if (j == 0) bus.drain_i = 1'b1;
      @(negedge clk);
      check("drn_ready", {bus.req1_ready, bus.req0_ready}, 2'b00);
      if (j == 5) check("drn_busy_last", bus.busy, 1'b1);
      if (j == 6) check("drn_busy_off", bus.busy, 1'b0);
    end
    check("drn_count", nres - base, 3);
    tick();
    bus.drain_i = 1'b0;
    @(negedge clk);
    check("drn_release", {bus.req1_ready, bus.req0_ready}, 2'b10);
    tick();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    repeat (8) tick();

    // Reset while two ops are in flight
    tick();
    bus.req0_valid = 1'b1; bus.req0_a = 35'h500; bus.req0_b = 35'h5;
    @(negedge clk);
    check("mr_grant_a", bus.req0_ready, 1'b1);
    tick();
    bus.req0_a = 35'h501;
    @(negedge clk);
    check("mr_grant_b", bus.req0_ready, 1'b1);
    tick();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b1; rst_n = 1'b0;
    @(negedge clk);
    check("mr_ready_in_rst", bus.req1_ready, 1'b0);
    tick();
    rst_n = 1'b1; bus.req1_valid = 1'b0;
    @(negedge clk);
    check("mr_add_valid", bus.add_valid_o, 1'b0);
    check("mr_add_a", bus.add_a_o, 0);
    check("mr_add_b", bus.add_b_o, 0);
    check("mr_res", {bus.res1_valid, bus.res0_valid}, 2'b00);
    check("mr_res_data", bus.res_data, 0);
    check("mr_busy", bus.busy, 1'b0);
    base = nres;
    tick();
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    bus.req0_a = 35'h800; bus.req0_b = 35'h6;
    @(negedge clk);
    check("mr_prio", {bus.req1_ready, bus.req0_ready}, 2'b01);
    tick();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    repeat (9) tick();
    @(negedge clk);
    check("mr_count", nres - base, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
